// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core widths and writeback grant encoding
package core_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LD   = 2'd2
  } grant_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register outstanding-write bits with set-wins-over-clear
module wb_scoreboard
  import core_pkg::*;
(
  input  logic                 clkin,
  input  logic                 rst_in,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0]  pending_out
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] pending_nxt;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    // Applying the set after the clear lets a same-edge re-issue keep the bit alive.
    pending_nxt = (pending_out & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clkin) begin
    if (rst_in) begin
      pending_out <= '0;
    end else begin
      pending_out <= {pending_nxt[NUM_REGS-1:1], 1'b0};
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - ALU/load writeback arbiter with starvation guard and scoreboard
module wb_arbiter
  import core_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                 clkin,
  input  logic                 rst_in,
  input  logic                 alu_valid_in,
  input  logic [REG_IDX_W-1:0] alu_idx_in,
  input  logic [XLEN-1:0]      alu_data_in,
  output logic                 alu_ready_out,
  input  logic                 ld_valid_in,
  input  logic [REG_IDX_W-1:0] ld_idx_in,
  input  logic [XLEN-1:0]      ld_data_in,
  output logic                 ld_ready_out,
  input  logic                 issue_valid_in,
  input  logic [REG_IDX_W-1:0] issue_idx_in,
  output logic                 wr_en_out,
  output logic [REG_IDX_W-1:0] wr_idx_out,
  output logic [XLEN-1:0]      wr_data_out,
  output logic [NUM_REGS-1:0]  pending_out
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  grant_t               grant;
  logic [3:0]           starve_cnt;
  logic [REG_IDX_W-1:0] gnt_idx;
  logic [XLEN-1:0]      gnt_data;

  always_comb begin
    grant = GRANT_NONE;
    if (rst_in) begin
      grant = GRANT_NONE;
    end else if (alu_valid_in && ld_valid_in) begin
      grant = (starve_cnt == STARVE_LIM) ? GRANT_LD : GRANT_ALU;
    end else if (alu_valid_in) begin
      grant = GRANT_ALU;
    end else if (ld_valid_in) begin
      grant = GRANT_LD;
    end
  end

  assign alu_ready_out = (grant == GRANT_ALU);
  assign ld_ready_out  = (grant == GRANT_LD);
  assign gnt_idx       = (grant == GRANT_LD) ? ld_idx_in  : alu_idx_in;
  assign gnt_data      = (grant == GRANT_LD) ? ld_data_in : alu_data_in;

  always_ff @(posedge clkin) begin
    if (rst_in || !ld_valid_in || grant == GRANT_LD) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Writes to x0 are consumed without touching the register file port.
  always_ff @(posedge clkin) begin
    if (rst_in) begin
      wr_en_out   <= 1'b0;
      wr_idx_out  <= '0;
      wr_data_out <= '0;
    end else if (grant != GRANT_NONE && gnt_idx != '0) begin
      wr_en_out   <= 1'b1;
      wr_idx_out  <= gnt_idx;
      wr_data_out <= gnt_data;
    end else begin
      wr_en_out   <= 1'b0;
    end
  end

  wb_scoreboard u_scoreboard (
    .clkin       (clkin),
    .rst_in      (rst_in),
    .set_en      (issue_valid_in),
    .set_idx     (issue_idx_in),
    .clr_en      (wr_en_out),
    .clr_idx     (wr_idx_out),
    .pending_out (pending_out)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed checks of wb_arbiter against a behavioural model
module tb_wb_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clkin = 1'b0;
  logic        rst_in;
  logic        alu_valid_in;
  logic [4:0]  alu_idx_in;
  logic [31:0] alu_data_in;
  logic        alu_ready_out;
  logic        ld_valid_in;
  logic [4:0]  ld_idx_in;
  logic [31:0] ld_data_in;
  logic        ld_ready_out;
  logic        issue_valid_in;
  logic [4:0]  issue_idx_in;
  logic        wr_en_out;
  logic [4:0]  wr_idx_out;
  logic [31:0] wr_data_out;
  logic [31:0] pending_out;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clkin          (clkin),
    .rst_in         (rst_in),
    .alu_valid_in   (alu_valid_in),
    .alu_idx_in     (alu_idx_in),
    .alu_data_in    (alu_data_in),
    .alu_ready_out  (alu_ready_out),
    .ld_valid_in    (ld_valid_in),
    .ld_idx_in      (ld_idx_in),
    .ld_data_in     (ld_data_in),
    .ld_ready_out   (ld_ready_out),
    .issue_valid_in (issue_valid_in),
    .issue_idx_in   (issue_idx_in),
    .wr_en_out      (wr_en_out),
    .wr_idx_out     (wr_idx_out),
    .wr_data_out    (wr_data_out),
    .pending_out    (pending_out)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: how many cycles the current load has waited, the write
  // the register file should see, and which registers still await a write.
  bit        model_on = 0;
  int        m_wait;
  bit        m_wr_en;
  int        m_wr_idx;
  bit [31:0] m_wr_data;
  bit        m_pend [32];

  always @(negedge clkin) begin
    int        eg;
    bit [31:0] pend_vec;
    bit        nxt_pend [32];
    eg = 0;
    if (!rst_in) begin
      if (alu_valid_in && ld_valid_in) eg = (m_wait >= STARVE_MAX) ? 2 : 1;
      else if (alu_valid_in)           eg = 1;
      else if (ld_valid_in)            eg = 2;
    end
    if (model_on) begin
      pend_vec = '0;
      for (int i = 0; i < 32; i++) pend_vec[i] = m_pend[i];
      chk("alu_ready", {31'd0, alu_ready_out}, {31'd0, eg == 1});
      chk("ld_ready",  {31'd0, ld_ready_out},  {31'd0, eg == 2});
      chk("wr_en",     {31'd0, wr_en_out},     {31'd0, m_wr_en});
      chk("wr_idx",    {27'd0, wr_idx_out},    32'(m_wr_idx));
      chk("wr_data",   wr_data_out,            m_wr_data);
      chk("pending",   pending_out,            pend_vec);
    end
    if (rst_in) begin
      m_wait    = 0;
      m_wr_en   = 0;
      m_wr_idx  = 0;
      m_wr_data = '0;
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      model_on  = 1;
    end else if (model_on) begin
      for (int i = 0; i < 32; i++) begin
        nxt_pend[i] = m_pend[i];
        if (m_wr_en && m_wr_idx == i) nxt_pend[i] = 0;
        if (issue_valid_in && int'(issue_idx_in) == i && i != 0) nxt_pend[i] = 1;
      end
      for (int i = 0; i < 32; i++) m_pend[i] = nxt_pend[i];
      m_wr_en = 0;
      if (eg == 1 && alu_idx_in != 0) begin
        m_wr_en = 1; m_wr_idx = int'(alu_idx_in); m_wr_data = alu_data_in;
      end else if (eg == 2 && ld_idx_in != 0) begin
        m_wr_en = 1; m_wr_idx = int'(ld_idx_in); m_wr_data = ld_data_in;
      end
      if (ld_valid_in && eg != 2) m_wait = (m_wait + 1 > STARVE_MAX) ? STARVE_MAX : m_wait + 1;
      else m_wait = 0;
    end
  end

  task automatic settle();
    @(negedge clkin);
  endtask

  task automatic adv();
    @(posedge clkin);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ld_acc;
    rst_in = 1; alu_valid_in = 0; alu_idx_in = 0; alu_data_in = 0;
    ld_valid_in = 0; ld_idx_in = 0; ld_data_in = 0;
    issue_valid_in = 0; issue_idx_in = 0;
    repeat (2) @(posedge clkin);
    #1 rst_in = 0;
    settle();
    chk("reset_wr_en", {31'd0, wr_en_out}, 32'd0);
    chk("reset_pending", pending_out, 32'd0);

    // Single ALU write
    adv();
    alu_valid_in = 1; alu_idx_in = 5; alu_data_in = 32'hDEADBEEF;
    settle();
    chk("t1_alu_ready", {31'd0, alu_ready_out}, 32'd1);
    adv();
    alu_valid_in = 0;
    settle();
    chk("t1_wr_en", {31'd0, wr_en_out}, 32'd1);
    chk("t1_wr_idx", {27'd0, wr_idx_out}, 32'd5);
    chk("t1_wr_data", wr_data_out, 32'hDEADBEEF);
    adv();
    settle();
    chk("t1_wr_en_drop", {31'd0, wr_en_out}, 32'd0);

    // Starvation: load wins on its 5th valid cycle
    adv();
    alu_valid_in = 1; alu_idx_in = 1; alu_data_in = 32'h1111;
    ld_valid_in = 1; ld_idx_in = 2; ld_data_in = 32'h1234;
    for (int k = 1; k <= 5; k++) begin
      settle();
      chk($sformatf("t2_ld_ready_c%0d", k), {31'd0, ld_ready_out}, {31'd0, k == 5});
      if (k < 5) adv();
    end
    adv();
    alu_valid_in = 0; ld_valid_in = 0;
    settle();
    chk("t2_wr_idx", {27'd0, wr_idx_out}, 32'd2);
    chk("t2_wr_data", wr_data_out, 32'h1234);
    chk("t2_starve_cnt", {28'd0, dut.starve_cnt}, 32'd0);

    // Load to x0 is consumed without a write
    adv();
    ld_valid_in = 1; ld_idx_in = 0; ld_data_in = 32'hFFFFFFFF;
    settle();
    chk("t3_ld_ready", {31'd0, ld_ready_out}, 32'd1);
    adv();
    ld_valid_in = 0;
    settle();
    chk("t3_wr_en", {31'd0, wr_en_out}, 32'd0);
    chk("t3_pending", pending_out, 32'd0);

    // Pending bit lifetime for x7
    adv();
    issue_valid_in = 1; issue_idx_in = 7;
    adv();
    issue_valid_in = 0;
    settle();
    chk("t4_pend_set", {31'd0, pending_out[7]}, 32'd1);
    adv();
    alu_valid_in = 1; alu_idx_in = 7; alu_data_in = 32'h77;
    adv();
    alu_valid_in = 0;
    settle();
    chk("t4_wr_en", {31'd0, wr_en_out}, 32'd1);
    chk("t4_pend_held", {31'd0, pending_out[7]}, 32'd1);
    adv();
    settle();
    chk("t4_pend_clr", {31'd0, pending_out[7]}, 32'd0);

    // Re-issue on the committing edge keeps the bit
    adv();
    alu_valid_in = 1; alu_idx_in = 7; alu_data_in = 32'h78;
    adv();
    alu_valid_in = 0; issue_valid_in = 1; issue_idx_in = 7;
    settle();
    chk("t5_wr_en", {31'd0, wr_en_out}, 32'd1);
    adv();
    issue_valid_in = 0;
    settle();
    chk("t5_pend_setwins", {31'd0, pending_out[7]}, 32'd1);

    // Reset clears pending and blocks grants while asserted
    adv();
    issue_valid_in = 1; issue_idx_in = 3;
    adv();
    issue_idx_in = 9;
    adv();
    issue_valid_in = 0;
    settle();
    chk("t6_pend_pre", pending_out, 32'h0000_0288);
    adv();
    rst_in = 1; alu_valid_in = 1; alu_idx_in = 4; alu_data_in = 32'hCAFE0004;
    settle();
    chk("t6_alu_ready_rst", {31'd0, alu_ready_out}, 32'd0);
    adv();
    rst_in = 0;
    settle();
    chk("t6_pend_rst", pending_out, 32'd0);
    chk("t6_wr_en_rst", {31'd0, wr_en_out}, 32'd0);
    chk("t6_alu_ready_post", {31'd0, alu_ready_out}, 32'd1);
    adv();
    alu_valid_in = 0;
    settle();
    chk("t6_wr_idx_post", {27'd0, wr_idx_out}, 32'd4);

    // Randomized traffic; the load is held until accepted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clkin);
      ld_acc = ld_ready_out;
      adv();
      rst_in         = ($urandom_range(0, 199) == 0);
      alu_valid_in   = ($urandom_range(0, 3) != 0);
      alu_idx_in     = 5'($urandom_range(0, 31));
      alu_data_in    = $urandom;
      if (!(ld_valid_in && !ld_acc)) begin
        ld_valid_in = ($urandom_range(0, 1) != 0);
        ld_idx_in   = 5'($urandom_range(0, 31));
        ld_data_in  = $urandom;
      end
      issue_valid_in = ($urandom_range(0, 2) == 0);
      issue_idx_in   = 5'($urandom_range(0, 31));
    end
    adv();
    alu_valid_in = 0; ld_valid_in = 0; issue_valid_in = 0; rst_in = 0;
    repeat (3) settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
